rr_stage: RTL and testbench

//   Register-read stage feeding the RR/EX pipeline register. Holds the

---
 rtl/rr_stage.sv | 142 ++++++++++++++
 tb/tb_rr_stage.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_stage.sv
// Register-read stage: register file with write-back bypass, EX/MEM operand
// forwarding, and load-use hazard detection driving a one-cycle RR/EX bubble.
module rr_stage #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int AW     = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              br_taken,
  input  logic [AW-1:0]     src1_addr,
  input  logic [AW-1:0]     src2_addr,
  input  logic              src1_used,
  input  logic              src2_used,
  input  logic              ex_wr_en,
  input  logic              ex_is_load,
  input  logic [AW-1:0]     ex_dest,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              mem_wr_en,
  input  logic [AW-1:0]     mem_dest,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] D1_out,
  output logic [DATA_W-1:0] D2_out,
  output logic [DATA_W-1:0] D1_forward,
  output logic              D1_forward_en,
  output logic [DATA_W-1:0] D2_forward,
  output logic              D2_forward_en,
  output logic              freeze,
  output logic              stall_upstream,
  output logic [CNT_W-1:0]  stall_count
);

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  logic [DATA_W-1:0] regFile_q [NREG];
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  stallCnt_q, stallCnt_d;
  logic              hazard;
  logic              stallReq;
  logic              use1, use2;

  // Reset has priority over a same-cycle write-back.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regFile_q[i] <= '0;
      end
      state_q    <= RUN;
      stallCnt_q <= '0;
    end else begin
      if (wb_en) begin
        regFile_q[wb_addr] <= wb_data;
      end
      state_q    <= state_d;
      stallCnt_q <= stallCnt_d;
    end
  end

  always_comb begin
    D1_out = regFile_q[src1_addr];
    D2_out = regFile_q[src2_addr];
    if (wb_en && (wb_addr == src1_addr)) begin
      D1_out = wb_data;
    end
    if (wb_en && (wb_addr == src2_addr)) begin
      D2_out = wb_data;
    end
  end

  assign use1 = valid_in && src1_used;
  assign use2 = valid_in && src2_used;

  // A load in EX has no data yet, so it is never an EX forwarding source.
  always_comb begin
    D1_forward    = '0;
    D1_forward_en = 1'b0;
    D2_forward    = '0;
    D2_forward_en = 1'b0;
    if (use1 && ex_wr_en && !ex_is_load && (ex_dest == src1_addr)) begin
      D1_forward    = ex_result;
      D1_forward_en = 1'b1;
    end else if (use1 && mem_wr_en && (mem_dest == src1_addr)) begin
      D1_forward    = mem_result;
      D1_forward_en = 1'b1;
    end
    if (use2 && ex_wr_en && !ex_is_load && (ex_dest == src2_addr)) begin
      D2_forward    = ex_result;
      D2_forward_en = 1'b1;
    end else if (use2 && mem_wr_en && (mem_dest == src2_addr)) begin
      D2_forward    = mem_result;
      D2_forward_en = 1'b1;
    end
  end

  assign hazard = valid_in && ex_wr_en && ex_is_load &&
                  ((src1_used && (ex_dest == src1_addr)) ||
                   (src2_used && (ex_dest == src2_addr)));

  always_comb begin
    state_d  = state_q;
    stallReq = 1'b0;
    case (state_q)
      RUN: begin
        if (hazard && !br_taken) begin
          stallReq = 1'b1;
          state_d  = STALL;
        end
      end
      STALL: begin
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
    if (br_taken) begin
      state_d = RUN;
    end
  end

  // Stall outputs are forced low while reset is held.
  assign freeze         = stallReq && rst;
  assign stall_upstream = stallReq && rst;

  always_comb begin
    stallCnt_d = stallCnt_q;
    if (freeze && (stallCnt_q != {CNT_W{1'b1}})) begin
      stallCnt_d = stallCnt_q + 1'b1;
    end
  end

  assign stall_count = stallCnt_q;

endmodule

// File: tb/tb_rr_stage.sv
// Self-checking bench for rr_stage: table of directed vectors plus saturation
// and randomized forwarding sequences, all checked through a scoreboard queue.
module tb_rr_stage;

  localparam int DATA_W = 16;
  localparam int NREG   = 8;
  localparam int AW     = 3;
  localparam int CNT_W  = 3;

  typedef struct {
    logic              rst;
    logic              valid;
    logic              br;
    logic              s1Used;
    logic              s2Used;
    logic              exWr;
    logic              exLoad;
    logic              memWr;
    logic              wbEn;
    logic [AW-1:0]     s1;
    logic [AW-1:0]     s2;
    logic [AW-1:0]     exDest;
    logic [AW-1:0]     memDest;
    logic [AW-1:0]     wbAddr;
    logic [DATA_W-1:0] exRes;
    logic [DATA_W-1:0] memRes;
    logic [DATA_W-1:0] wbData;
  } stim_t;

  typedef struct {
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
    logic [DATA_W-1:0] f1;
    logic              f1En;
    logic [DATA_W-1:0] f2;
    logic              f2En;
    logic              frz;
    logic [CNT_W-1:0]  cnt;
  } exp_t;

  typedef struct {
    string name;
    stim_t s;
    exp_t  e;
  } vec_t;

  logic              clk;
  logic              rst;
  logic              valid_in, br_taken, src1_used, src2_used;
  logic [AW-1:0]     src1_addr, src2_addr, ex_dest, mem_dest, wb_addr;
  logic              ex_wr_en, ex_is_load, mem_wr_en, wb_en;
  logic [DATA_W-1:0] ex_result, mem_result, wb_data;
  logic [DATA_W-1:0] D1_out, D2_out, D1_forward, D2_forward;
  logic              D1_forward_en, D2_forward_en, freeze, stall_upstream;
  logic [CNT_W-1:0]  stall_count;

  int   numChecks = 0;
  int   numFails  = 0;
  exp_t sbQ[$];
  vec_t vecs[$];

  rr_stage #(
    .DATA_W(DATA_W),
    .NREG  (NREG),
    .AW    (AW),
    .CNT_W (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .valid_in      (valid_in),
    .br_taken      (br_taken),
    .src1_addr     (src1_addr),
    .src2_addr     (src2_addr),
    .src1_used     (src1_used),
    .src2_used     (src2_used),
    .ex_wr_en      (ex_wr_en),
    .ex_is_load    (ex_is_load),
    .ex_dest       (ex_dest),
    .ex_result     (ex_result),
    .mem_wr_en     (mem_wr_en),
    .mem_dest      (mem_dest),
    .mem_result    (mem_result),
    .wb_en         (wb_en),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .D1_out        (D1_out),
    .D2_out        (D2_out),
    .D1_forward    (D1_forward),
    .D1_forward_en (D1_forward_en),
    .D2_forward    (D2_forward),
    .D2_forward_en (D2_forward_en),
    .freeze        (freeze),
    .stall_upstream(stall_upstream),
    .stall_count   (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t idle();
    stim_t s;
    s = '{rst: 1'b1, default: '0};
    return s;
  endfunction

  function automatic stim_t loadUse();
    stim_t s;
    s        = idle();
    s.valid  = 1'b1;
    s.s2     = 3'd4;
    s.s2Used = 1'b1;
    s.exWr   = 1'b1;
    s.exLoad = 1'b1;
    s.exDest = 3'd4;
    s.exRes  = 16'h0099;
    return s;
  endfunction

  function automatic exp_t mkExp(logic [15:0] d1, logic [15:0] d2, logic [15:0] f1,
                                 logic f1En, logic [15:0] f2, logic f2En, logic frz,
                                 logic [CNT_W-1:0] cnt);
    exp_t e;
    e = '{d1: d1, d2: d2, f1: f1, f1En: f1En, f2: f2, f2En: f2En, frz: frz, cnt: cnt};
    return e;
  endfunction

  task automatic addVec(input string name, input stim_t s, input exp_t e);
    vec_t v;
    v.name = name;
    v.s    = s;
    v.e    = e;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs just after the edge and queue its expectation.
  task automatic applyStimulus(input stim_t s, input exp_t e);
    @(posedge clk);
    #1;
    rst        = s.rst;
    valid_in   = s.valid;
    br_taken   = s.br;
    src1_addr  = s.s1;
    src2_addr  = s.s2;
    src1_used  = s.s1Used;
    src2_used  = s.s2Used;
    ex_wr_en   = s.exWr;
    ex_is_load = s.exLoad;
    ex_dest    = s.exDest;
    ex_result  = s.exRes;
    mem_wr_en  = s.memWr;
    mem_dest   = s.memDest;
    mem_result = s.memRes;
    wb_en      = s.wbEn;
    wb_addr    = s.wbAddr;
    wb_data    = s.wbData;
    sbQ.push_back(e);
  endtask

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] req);
    numChecks++;
    if (act !== req) begin
      numFails++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, act, req);
    end
  endtask

  // Sample on the falling edge, away from the register updates.
  task automatic checkOutput(input string name);
    exp_t e;
    @(negedge clk);
    if (sbQ.size() == 0) begin
      numChecks++;
      numFails++;
      $display("[TB] FAIL %s: scoreboard empty, got 0 entries, expected 1", name);
    end else begin
      e = sbQ.pop_front();
      cmp({name, "/D1_out"}, D1_out, e.d1);
      cmp({name, "/D2_out"}, D2_out, e.d2);
      cmp({name, "/D1_forward"}, D1_forward, e.f1);
      cmp({name, "/D1_forward_en"}, {15'd0, D1_forward_en}, {15'd0, e.f1En});
      cmp({name, "/D2_forward"}, D2_forward, e.f2);
      cmp({name, "/D2_forward_en"}, {15'd0, D2_forward_en}, {15'd0, e.f2En});
      cmp({name, "/freeze"}, {15'd0, freeze}, {15'd0, e.frz});
      cmp({name, "/stall_upstream"}, {15'd0, stall_upstream}, {15'd0, e.frz});
      cmp({name, "/stall_count"}, {13'd0, stall_count}, {13'd0, e.cnt});
    end
  endtask

  task automatic runVec(input string name, input stim_t s, input exp_t e);
    applyStimulus(s, e);
    checkOutput(name);
  endtask

  initial begin
    stim_t s;
    exp_t  e;
    logic [CNT_W-1:0] satA, satB;

    s = idle();
    rst        = 1'b0;
    valid_in   = s.valid;
    br_taken   = s.br;
    src1_addr  = s.s1;
    src2_addr  = s.s2;
    src1_used  = s.s1Used;
    src2_used  = s.s2Used;
    ex_wr_en   = s.exWr;
    ex_is_load = s.exLoad;
    ex_dest    = s.exDest;
    ex_result  = s.exRes;
    mem_wr_en  = s.memWr;
    mem_dest   = s.memDest;
    mem_result = s.memRes;
    wb_en      = s.wbEn;
    wb_addr    = s.wbAddr;
    wb_data    = s.wbData;

    s = idle(); s.rst = 1'b0;
    addVec("reset", s, mkExp(0, 0, 0, 0, 0, 0, 0, 0));
    s = idle(); s.wbEn = 1; s.wbAddr = 3; s.wbData = 16'h1234;
    addVec("wbWriteR3", s, mkExp(0, 0, 0, 0, 0, 0, 0, 0));
    s = idle(); s.valid = 1; s.s1 = 3; s.s1Used = 1;
    addVec("readR3", s, mkExp(16'h1234, 0, 0, 0, 0, 0, 0, 0));
    s = idle(); s.valid = 1; s.s2 = 5; s.s2Used = 1; s.wbEn = 1; s.wbAddr = 5; s.wbData = 16'hBEEF;
    addVec("wbBypass", s, mkExp(0, 16'hBEEF, 0, 0, 0, 0, 0, 0));
    s = idle(); s.valid = 1; s.s1 = 3; s.s2 = 5; s.s1Used = 1; s.s2Used = 1;
    addVec("readBoth", s, mkExp(16'h1234, 16'hBEEF, 0, 0, 0, 0, 0, 0));
    s = idle(); s.valid = 1; s.s1 = 2; s.s1Used = 1; s.exWr = 1; s.exDest = 2; s.exRes = 16'h0011;
    s.memWr = 1; s.memDest = 2; s.memRes = 16'h0022;
    addVec("exWins", s, mkExp(0, 0, 16'h0011, 1, 0, 0, 0, 0));
    s.exDest = 6;
    addVec("memFwd", s, mkExp(0, 0, 16'h0022, 1, 0, 0, 0, 0));
    s.exDest = 2; s.valid = 0;
    addVec("noValid", s, mkExp(0, 0, 0, 0, 0, 0, 0, 0));
    s.valid = 1; s.s1Used = 0;
    addVec("notUsed", s, mkExp(0, 0, 0, 0, 0, 0, 0, 0));
    s = idle(); s.valid = 1; s.s1 = 2; s.s2 = 2; s.s1Used = 1; s.s2Used = 1;
    s.exWr = 1; s.exDest = 2; s.exRes = 16'h0011;
    addVec("bothFwd", s, mkExp(0, 0, 16'h0011, 1, 16'h0011, 1, 0, 0));
    addVec("loadUse", loadUse(), mkExp(0, 0, 0, 0, 0, 0, 1, 0));
    s = idle(); s.valid = 1; s.s2 = 4; s.s2Used = 1; s.memWr = 1; s.memDest = 4; s.memRes = 16'h00AA;
    addVec("stallMemFwd", s, mkExp(0, 0, 0, 0, 16'h00AA, 1, 0, 1));
    s = loadUse(); s.br = 1;
    addVec("brFlush", s, mkExp(0, 0, 0, 0, 0, 0, 0, 1));
    addVec("runAfterBr", loadUse(), mkExp(0, 0, 0, 0, 0, 0, 1, 1));
    addVec("noDoubleStall", loadUse(), mkExp(0, 0, 0, 0, 0, 0, 0, 2));
    addVec("hazardAgain", loadUse(), mkExp(0, 0, 0, 0, 0, 0, 1, 2));
    addVec("brInStall", s, mkExp(0, 0, 0, 0, 0, 0, 0, 3));
    addVec("runAfterBr2", loadUse(), mkExp(0, 0, 0, 0, 0, 0, 1, 3));
    addVec("idle", idle(), mkExp(0, 0, 0, 0, 0, 0, 0, 4));
    s = idle(); s.wbEn = 1; s.wbAddr = 1; s.wbData = 16'h7777;
    addVec("wbWriteR1", s, mkExp(0, 0, 0, 0, 0, 0, 0, 4));
    addVec("enterStall", loadUse(), mkExp(0, 0, 0, 0, 0, 0, 1, 4));
    s = idle(); s.rst = 0; s.valid = 1; s.s1 = 1; s.s1Used = 1; s.wbEn = 1; s.wbAddr = 2; s.wbData = 16'h5555;
    addVec("resetInStall", s, mkExp(16'h7777, 0, 0, 0, 0, 0, 0, 5));
    s = idle(); s.valid = 1; s.s1 = 1; s.s2 = 2; s.s1Used = 1; s.s2Used = 1;
    s.exWr = 1; s.exLoad = 1; s.exDest = 1;
    addVec("postReset", s, mkExp(0, 0, 0, 0, 0, 0, 1, 0));
    addVec("idleStall", idle(), mkExp(0, 0, 0, 0, 0, 0, 0, 1));
    s = loadUse(); s.rst = 0;
    addVec("resetInRun", s, mkExp(0, 0, 0, 0, 0, 0, 0, 1));
    addVec("resetRelease", idle(), mkExp(0, 0, 0, 0, 0, 0, 0, 0));
    addVec("hazardAfterRst", loadUse(), mkExp(0, 0, 0, 0, 0, 0, 1, 0));
    addVec("idle2", idle(), mkExp(0, 0, 0, 0, 0, 0, 0, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      runVec(vecs[i].name, vecs[i].s, vecs[i].e);
    end

    // Counter saturation: each hazard/idle pair adds one stall cycle.
    for (int k = 0; k < 10; k++) begin
      satA = (k + 1 > 7) ? 3'd7 : 3'(k + 1);
      satB = (k + 2 > 7) ? 3'd7 : 3'(k + 2);
      runVec("satHazard", loadUse(), mkExp(0, 0, 0, 0, 0, 0, 1, satA));
      runVec("satIdle", idle(), mkExp(0, 0, 0, 0, 0, 0, 0, satB));
    end

    // Randomized forwarding with no loads and no write-backs; registers are all zero.
    for (int k = 0; k < 24; k++) begin
      s = idle();
      s.valid   = 1'($urandom_range(0, 3) != 0);
      s.s1Used  = 1'($urandom_range(0, 3) != 0);
      s.s2Used  = 1'($urandom_range(0, 3) != 0);
      s.s1      = 3'($urandom_range(0, 7));
      s.s2      = 3'($urandom_range(0, 7));
      s.exWr    = 1'($urandom_range(0, 1));
      s.memWr   = 1'($urandom_range(0, 1));
      s.exDest  = 3'($urandom_range(0, 7));
      s.memDest = (k % 3 == 0) ? s.exDest : 3'($urandom_range(0, 7));
      s.exRes   = 16'($urandom_range(1, 65535));
      s.memRes  = 16'($urandom_range(1, 65535));
      e = mkExp(0, 0, 0, 0, 0, 0, 0, 3'd7);
      if (s.valid && s.s1Used && s.exWr && s.exDest == s.s1) begin
        e.f1 = s.exRes; e.f1En = 1;
      end else if (s.valid && s.s1Used && s.memWr && s.memDest == s.s1) begin
        e.f1 = s.memRes; e.f1En = 1;
      end
      if (s.valid && s.s2Used && s.exWr && s.exDest == s.s2) begin
        e.f2 = s.exRes; e.f2En = 1;
      end else if (s.valid && s.s2Used && s.memWr && s.memDest == s.s2) begin
        e.f2 = s.memRes; e.f2En = 1;
      end
      runVec("randFwd", s, e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
